// File: rtl/fip_seq_ctrl.sv
// Sequencing controller for the Winograd fast-inner-product array:
// issues operand chunks, accumulates chunk sums, returns the corrected dot product.
module fip_seq_ctrl #(
    parameter int IN_SIZE_0  = 4,
    parameter int IN_SIZE_1  = 8,
    parameter int ARRAY_SIZE = 8,
    parameter int LEN_W      = 8,
    parameter int SUM_SIZE   = 22,
    parameter int ACC_SIZE   = 32
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           cmd_valid_i,
    output logic                           cmd_ready_o,
    input  logic [LEN_W-1:0]               cmd_len_i,
    input  logic [ACC_SIZE-1:0]            cmd_corr_i,
    input  logic                           op_valid_i,
    output logic                           op_ready_o,
    input  logic [ARRAY_SIZE*IN_SIZE_0-1:0] op_0_i,
    input  logic [ARRAY_SIZE*IN_SIZE_1-1:0] op_1_i,
    output logic [ARRAY_SIZE*IN_SIZE_0-1:0] arr_in_0_o,
    output logic [ARRAY_SIZE*IN_SIZE_1-1:0] arr_in_1_o,
    output logic                           arr_valid_o,
    input  logic                           red_valid_i,
    input  logic [SUM_SIZE-1:0]            red_sum_i,
    output logic                           res_valid_o,
    input  logic                           res_ready_i,
    output logic [ACC_SIZE-1:0]            res_data_o,
    output logic                           busy_o,
    output logic                           err_o
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    state_t              state;
    logic [LEN_W-1:0]    len;
    logic [LEN_W-1:0]    issue_cnt;
    logic [LEN_W-1:0]    recv_cnt;
    logic [ACC_SIZE-1:0] acc;

    logic                cmd_fire;
    logic                op_fire;
    logic                red_take;
    logic                red_stray;
    logic [LEN_W-1:0]    issue_nxt;
    logic [LEN_W-1:0]    recv_nxt;
    logic [ACC_SIZE-1:0] sum_ext;
    logic [ACC_SIZE-1:0] acc_nxt;
    logic                all_done;

    assign cmd_ready_o = (state == IDLE);
    assign op_ready_o  = (state == ISSUE);
    assign busy_o      = (state != IDLE);

    assign cmd_fire  = cmd_valid_i & cmd_ready_o;
    assign op_fire   = op_valid_i & op_ready_o;
    assign red_take  = red_valid_i & ((state == ISSUE) | (state == DRAIN));
    assign red_stray = red_valid_i & ((state == IDLE) | (state == DONE));

    // Sign-extend (or wrap) the tree sum into accumulator width.
    assign sum_ext   = ACC_SIZE'($signed(red_sum_i));
    assign acc_nxt   = red_take ? (acc + sum_ext) : acc;
    assign issue_nxt = issue_cnt + LEN_W'(op_fire);
    assign recv_nxt  = recv_cnt + LEN_W'(red_take);
    assign all_done  = (issue_nxt == len) && (recv_nxt == len);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            len         <= '0;
            issue_cnt   <= '0;
            recv_cnt    <= '0;
            acc         <= '0;
            arr_in_0_o  <= '0;
            arr_in_1_o  <= '0;
            arr_valid_o <= 1'b0;
            res_valid_o <= 1'b0;
            res_data_o  <= '0;
            err_o       <= 1'b0;
        end else begin
            arr_valid_o <= 1'b0;
            if (red_stray) begin
                err_o <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (cmd_fire) begin
                        len       <= cmd_len_i;
                        issue_cnt <= '0;
                        recv_cnt  <= '0;
                        acc       <= -cmd_corr_i;
                        err_o     <= 1'b0;
                        if (cmd_len_i == '0) begin
                            state       <= DONE;
                            res_valid_o <= 1'b1;
                            res_data_o  <= -cmd_corr_i;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE, DRAIN: begin
                    if (op_fire) begin
                        arr_in_0_o  <= op_0_i;
                        arr_in_1_o  <= op_1_i;
                        arr_valid_o <= 1'b1;
                    end
                    issue_cnt <= issue_nxt;
                    recv_cnt  <= recv_nxt;
                    acc       <= acc_nxt;
                    if (all_done) begin
                        state       <= DONE;
                        res_valid_o <= 1'b1;
                        res_data_o  <= acc_nxt;
                    end else if (state == ISSUE && issue_nxt == len) begin
                        state <= DRAIN;
                    end
                end
                DONE: begin
                    if (res_ready_i) begin
                        res_valid_o <= 1'b0;
                        state       <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fip_seq_ctrl.sv
// Directed self-checking bench for fip_seq_ctrl.
// Uses a 32-bit chunk sum so the accumulator wrap case can be driven.
module tb_fip_seq_ctrl;

    localparam int IN_SIZE_0  = 4;
    localparam int IN_SIZE_1  = 8;
    localparam int ARRAY_SIZE = 8;
    localparam int LEN_W      = 8;
    localparam int SUM_SIZE   = 32;
    localparam int ACC_SIZE   = 32;

    logic                            clk_i = 1'b0;
    logic                            rst_ni;
    logic                            cmd_valid_i;
    logic                            cmd_ready_o;
    logic [LEN_W-1:0]                cmd_len_i;
    logic [ACC_SIZE-1:0]             cmd_corr_i;
    logic                            op_valid_i;
    logic                            op_ready_o;
    logic [ARRAY_SIZE*IN_SIZE_0-1:0] op_0_i;
    logic [ARRAY_SIZE*IN_SIZE_1-1:0] op_1_i;
    logic [ARRAY_SIZE*IN_SIZE_0-1:0] arr_in_0_o;
    logic [ARRAY_SIZE*IN_SIZE_1-1:0] arr_in_1_o;
    logic                            arr_valid_o;
    logic                            red_valid_i;
    logic [SUM_SIZE-1:0]             red_sum_i;
    logic                            res_valid_o;
    logic                            res_ready_i;
    logic [ACC_SIZE-1:0]             res_data_o;
    logic                            busy_o;
    logic                            err_o;

    int checks   = 0;
    int failures = 0;

    logic [31:0] ch0 [3];
    logic [63:0] ch1 [3];
    logic [31:0] sums3 [3];

    fip_seq_ctrl #(
        .IN_SIZE_0 (IN_SIZE_0),
        .IN_SIZE_1 (IN_SIZE_1),
        .ARRAY_SIZE(ARRAY_SIZE),
        .LEN_W     (LEN_W),
        .SUM_SIZE  (SUM_SIZE),
        .ACC_SIZE  (ACC_SIZE)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .cmd_valid_i(cmd_valid_i),
        .cmd_ready_o(cmd_ready_o),
        .cmd_len_i  (cmd_len_i),
        .cmd_corr_i (cmd_corr_i),
        .op_valid_i (op_valid_i),
        .op_ready_o (op_ready_o),
        .op_0_i     (op_0_i),
        .op_1_i     (op_1_i),
        .arr_in_0_o (arr_in_0_o),
        .arr_in_1_o (arr_in_1_o),
        .arr_valid_o(arr_valid_o),
        .red_valid_i(red_valid_i),
        .red_sum_i  (red_sum_i),
        .res_valid_o(res_valid_o),
        .res_ready_i(res_ready_i),
        .res_data_o (res_data_o),
        .busy_o     (busy_o),
        .err_o      (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        ch0[0] = 32'h7654_3210;
        ch0[1] = 32'h89AB_CDEF;
        ch0[2] = 32'h1357_9BDF;
        ch1[0] = 64'h0123_4567_89AB_CDEF;
        ch1[1] = 64'hFEDC_BA98_7654_3210;
        ch1[2] = 64'h5A5A_A5A5_3C3C_C3C3;
        sums3[0] = 32'd100;
        sums3[1] = 32'd200;
        sums3[2] = -32'sd50;

        rst_ni      = 1'b0;
        cmd_valid_i = 1'b0;
        cmd_len_i   = '0;
        cmd_corr_i  = '0;
        op_valid_i  = 1'b0;
        op_0_i      = '0;
        op_1_i      = '0;
        red_valid_i = 1'b0;
        red_sum_i   = '0;
        res_ready_i = 1'b0;

        // reset
        step();
        step();
        chk("rst_arr_valid", 64'(arr_valid_o), 64'd0);
        chk("rst_res_valid", 64'(res_valid_o), 64'd0);
        chk("rst_res_data", 64'(res_data_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        chk("rst_arr_in_0", 64'(arr_in_0_o), 64'd0);
        chk("rst_arr_in_1", arr_in_1_o, 64'd0);
        rst_ni = 1'b1;
        step();
        chk("rel_cmd_ready", 64'(cmd_ready_o), 64'd1);
        chk("rel_busy", 64'(busy_o), 64'd0);
        chk("rel_op_ready", 64'(op_ready_o), 64'd0);

        // len=0, corr=5
        cmd_valid_i = 1'b1;
        cmd_len_i   = 8'd0;
        cmd_corr_i  = 32'd5;
        step();
        cmd_valid_i = 1'b0;
        chk("l0_res_valid", 64'(res_valid_o), 64'd1);
        chk("l0_res_data", 64'(res_data_o), 64'hFFFF_FFFB);
        chk("l0_arr_valid", 64'(arr_valid_o), 64'd0);
        chk("l0_cmd_ready", 64'(cmd_ready_o), 64'd0);
        res_ready_i = 1'b1;
        step();
        res_ready_i = 1'b0;
        chk("l0_res_drop", 64'(res_valid_o), 64'd0);
        chk("l0_cmd_ready_back", 64'(cmd_ready_o), 64'd1);

        // len=3, corr=10, back-to-back chunks, sums two cycles after strobe
        cmd_valid_i = 1'b1;
        cmd_len_i   = 8'd3;
        cmd_corr_i  = 32'd10;
        step();
        cmd_valid_i = 1'b0;
        chk("l3_op_ready", 64'(op_ready_o), 64'd1);
        for (int c = 1; c <= 6; c++) begin
            op_valid_i  = (c <= 3);
            op_0_i      = (c <= 3) ? ch0[c-1] : '0;
            op_1_i      = (c <= 3) ? ch1[c-1] : '0;
            red_valid_i = (c >= 4);
            red_sum_i   = (c >= 4) ? sums3[c-4] : '0;
            step();
            if (c <= 3) begin
                chk($sformatf("l3_arr_valid_%0d", c), 64'(arr_valid_o), 64'd1);
                chk($sformatf("l3_arr_in_0_%0d", c), 64'(arr_in_0_o), 64'(ch0[c-1]));
                chk($sformatf("l3_arr_in_1_%0d", c), arr_in_1_o, ch1[c-1]);
            end else begin
                chk($sformatf("l3_arr_idle_%0d", c), 64'(arr_valid_o), 64'd0);
                chk($sformatf("l3_arr_hold_%0d", c), 64'(arr_in_0_o), 64'(ch0[2]));
            end
            if (c == 3) chk("l3_drain_op_ready", 64'(op_ready_o), 64'd0);
            if (c == 5) chk("l3_res_early", 64'(res_valid_o), 64'd0);
        end
        op_valid_i  = 1'b0;
        red_valid_i = 1'b0;
        chk("l3_res_valid", 64'(res_valid_o), 64'd1);
        chk("l3_res_data", 64'(res_data_o), 64'd240);
        res_ready_i = 1'b1;
        step();
        res_ready_i = 1'b0;
        chk("l3_res_drop", 64'(res_valid_o), 64'd0);

        // len=4 with operand bubbles and a stalled result; corr=3, sums 1..4
        cmd_valid_i = 1'b1;
        cmd_len_i   = 8'd4;
        cmd_corr_i  = 32'd3;
        step();
        cmd_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            op_valid_i = 1'b1;
            op_0_i     = 32'(i + 1) * 32'h1111_1111;
            op_1_i     = 64'(i + 1) * 64'h0101_0101_0101_0101;
            step();
            op_valid_i = 1'b0;
            chk($sformatf("l4_arr_valid_%0d", i), 64'(arr_valid_o), 64'd1);
            chk($sformatf("l4_arr_in_0_%0d", i), 64'(arr_in_0_o),
                64'((i + 1) * 32'h1111_1111));
            red_valid_i = 1'b1;
            red_sum_i   = 32'(i + 1);
            step();
            red_valid_i = 1'b0;
            chk($sformatf("l4_bubble_%0d", i), 64'(arr_valid_o), 64'd0);
            chk($sformatf("l4_busy_%0d", i), 64'(busy_o), 64'd1);
            chk($sformatf("l4_cmd_ready_%0d", i), 64'(cmd_ready_o), 64'd0);
        end
        for (int s = 0; s < 5; s++) begin
            chk($sformatf("l4_stall_valid_%0d", s), 64'(res_valid_o), 64'd1);
            chk($sformatf("l4_stall_data_%0d", s), 64'(res_data_o), 64'd7);
            chk($sformatf("l4_stall_cmd_ready_%0d", s), 64'(cmd_ready_o), 64'd0);
            chk($sformatf("l4_stall_busy_%0d", s), 64'(busy_o), 64'd1);
            step();
        end
        res_ready_i = 1'b1;
        step();
        res_ready_i = 1'b0;
        chk("l4_res_drop", 64'(res_valid_o), 64'd0);
        chk("l4_cmd_ready_back", 64'(cmd_ready_o), 64'd1);

        // spurious sum in IDLE, then command with a coincident stray sum
        red_valid_i = 1'b1;
        red_sum_i   = 32'd999;
        step();
        chk("err_set_idle", 64'(err_o), 64'd1);
        cmd_valid_i = 1'b1;
        cmd_len_i   = 8'd2;
        cmd_corr_i  = 32'd0;
        step();
        cmd_valid_i = 1'b0;
        red_valid_i = 1'b0;
        chk("err_clear_wins", 64'(err_o), 64'd0);
        op_valid_i = 1'b1;
        op_0_i     = 32'hAAAA_5555;
        op_1_i     = 64'h1;
        step();
        op_0_i     = 32'h5555_AAAA;
        op_1_i     = 64'h2;
        step();
        op_valid_i = 1'b0;
        chk("wrap_op_ready", 64'(op_ready_o), 64'd0);
        red_valid_i = 1'b1;
        red_sum_i   = 32'h7FFF_FFFF;
        step();
        red_sum_i   = 32'h0000_0001;
        step();
        red_valid_i = 1'b0;
        chk("wrap_res_valid", 64'(res_valid_o), 64'd1);
        chk("wrap_res_data", 64'(res_data_o), 64'h8000_0000);
        red_valid_i = 1'b1;
        red_sum_i   = 32'd77;
        step();
        red_valid_i = 1'b0;
        chk("err_set_done", 64'(err_o), 64'd1);
        chk("done_data_kept", 64'(res_data_o), 64'h8000_0000);
        res_ready_i = 1'b1;
        step();
        res_ready_i = 1'b0;

        // reset asserted in DRAIN after 2 of 3 sums
        cmd_valid_i = 1'b1;
        cmd_len_i   = 8'd3;
        cmd_corr_i  = 32'd0;
        step();
        cmd_valid_i = 1'b0;
        chk("err_clear_cmd", 64'(err_o), 64'd0);
        op_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            op_0_i = ch0[i];
            op_1_i = ch1[i];
            step();
        end
        op_valid_i  = 1'b0;
        red_valid_i = 1'b1;
        red_sum_i   = 32'd5;
        step();
        red_sum_i   = 32'd6;
        step();
        red_valid_i = 1'b0;
        chk("rd_busy_pre", 64'(busy_o), 64'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("rd_busy", 64'(busy_o), 64'd0);
        chk("rd_arr_in_0", 64'(arr_in_0_o), 64'd0);
        chk("rd_arr_in_1", arr_in_1_o, 64'd0);
        chk("rd_res_valid", 64'(res_valid_o), 64'd0);
        chk("rd_res_data", 64'(res_data_o), 64'd0);
        chk("rd_cmd_ready", 64'(cmd_ready_o), 64'd1);
        step();
        step();
        rst_ni = 1'b1;
        step();
        chk("rd_rel_res_valid", 64'(res_valid_o), 64'd0);
        cmd_valid_i = 1'b1;
        cmd_len_i   = 8'd1;
        cmd_corr_i  = 32'd0;
        step();
        cmd_valid_i = 1'b0;
        op_valid_i  = 1'b1;
        op_0_i      = 32'h0F0F_0F0F;
        op_1_i      = 64'h3;
        step();
        op_valid_i  = 1'b0;
        chk("fresh_arr_in_0", 64'(arr_in_0_o), 64'h0F0F_0F0F);
        red_valid_i = 1'b1;
        red_sum_i   = 32'd42;
        step();
        red_valid_i = 1'b0;
        chk("fresh_res_valid", 64'(res_valid_o), 64'd1);
        chk("fresh_res_data", 64'(res_data_o), 64'd42);
        res_ready_i = 1'b1;
        step();
        res_ready_i = 1'b0;
        chk("fresh_idle", 64'(busy_o), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fip_seq_ctrl.md
Name: fip_seq_ctrl

Overview:
Sequencing controller for the fast-inner-product multiply array (paired add-then-multiply, Winograd style).
- Accepts a dot-product job and streams ARRAY_SIZE-element operand chunks into the array's input registers, one chunk per cycle.
- Collects per-chunk sums from the downstream partial-product reduction tree, accumulates them, and applies the job's Winograd correction term.
- Returns the finished dot product over a valid/ready result port. Sits between the operand fetch/stream logic and the array plus reduction tree.

Parameters:
IN_SIZE_0, 4, element width of operand vector 0
IN_SIZE_1, 8, element width of operand vector 1
ARRAY_SIZE, 8, elements per chunk; even, >=2
LEN_W, 8, width of job length field (in chunks)
SUM_SIZE, 22, width of the signed per-chunk sum from the reduction tree
ACC_SIZE, 32, signed accumulator and result width

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
cmd_valid_i  in  1  job command valid
cmd_ready_o  out  1  job command accepted when both high
cmd_len_i  in  LEN_W  number of chunks in the job; 0 is legal
cmd_corr_i  in  ACC_SIZE  signed precomputed correction (sum of a2j*a2j+1 plus sum of b2j*b2j+1)
op_valid_i  in  1  operand chunk valid
op_ready_o  out  1  operand chunk accepted when both high
op_0_i  in  ARRAY_SIZE*IN_SIZE_0  chunk of vector 0, element k at bits [k*IN_SIZE_0 +: IN_SIZE_0]
op_1_i  in  ARRAY_SIZE*IN_SIZE_1  chunk of vector 1, same packing
arr_in_0_o  out  ARRAY_SIZE*IN_SIZE_0  registered array operand 0
arr_in_1_o  out  ARRAY_SIZE*IN_SIZE_1  registered array operand 1
arr_valid_o  out  1  one-cycle strobe: arr_in_* hold a new chunk
red_valid_i  in  1  reduction tree sum valid (one pulse per issued chunk, in order)
red_sum_i  in  SUM_SIZE  signed chunk sum
res_valid_o  out  1  result valid
res_ready_i  in  1  result consumed when both high
res_data_o  out  ACC_SIZE  signed dot product
busy_o  out  1  high in any state other than IDLE
err_o  out  1  sticky: red_valid_i received outside an active job

Behaviour:
- Reset (async, rst_ni low): state IDLE; all counters, accumulator, arr_in_*, arr_valid_o, res_valid_o, res_data_o, busy_o and err_o are 0. Asserting reset mid-job aborts the job silently; no result is produced.
- FSM states are IDLE, ISSUE, DRAIN and DONE.
- IDLE: cmd_ready_o=1. On cmd handshake:
  - latch len; clear issue and receive counters; acc <= -cmd_corr_i (two's complement, ACC_SIZE); err_o <= 0.
  - Next state is ISSUE, or DONE when len==0.
- ISSUE: op_ready_o=1 (0 in every other state). On op handshake:
  - arr_in_* <= op_*; arr_valid_o=1 in the following cycle only; issue count +1.
  - The handshake for chunk len-1 moves the FSM to DRAIN.
  - Sustains one chunk per cycle while op_valid_i is held high.
  - arr_in_* hold their value between handshakes.
- DRAIN: waits for the remaining sums. No operands are accepted.
- Accumulation runs in ISSUE and DRAIN: on red_valid_i, acc <= acc + sign-extend(red_sum_i) and receive count +1. Overflow wraps modulo 2^ACC_SIZE.
- When the receive count reaches len, the next state is DONE. This can happen in DRAIN, or in ISSUE only after the final issue.
- DONE:
  - res_valid_o=1 and res_data_o=acc, held stable until res_ready_i.
  - On handshake, res_valid_o drops and the next state is IDLE, so cmd_ready_o rises the following cycle.
- Latency:
  - Command accepted in cycle T; first op handshake at T+1 or later.
  - res_valid_o asserts in the cycle after the last red_valid_i.
  - For len==0, res_valid_o asserts at T+1.
- A red_valid_i in IDLE or DONE is ignored for accumulation and sets err_o. A command on the same cycle as a spurious red_valid_i clears err_o (clear wins).
- The controller never stalls the reduction tree; red_valid_i has no ready.

Test Plan:
- Reset: hold rst_ni low, then release -> all outputs 0, cmd_ready_o=1 on the first cycle after release, busy_o=0.
- len=0, corr=5 -> res_valid_o one cycle after cmd handshake, res_data_o=0xFFFFFFFB; no arr_valid_o pulse.
- len=3, corr=10, back-to-back chunks, bench returns sums 100, 200, -50 two cycles after each arr_valid_o -> arr_valid_o high 3 consecutive cycles, arr_in_* match each chunk, res_data_o=240.
- len=4 with op_valid_i bubbles (1 cycle between chunks) and res_ready_i low for 5 cycles -> result and res_valid_o stable while stalled; cmd_ready_o=0 until the result handshake; busy_o=1 throughout.
- Spurious red_valid_i in IDLE -> err_o=1 and the next job's result is unaffected; err_o=0 after that job's cmd handshake. Accumulator wrap: corr=0, sums 0x7FFFFFFF then 1 (ACC_SIZE=32 with a wider test SUM_SIZE) -> res_data_o=0x80000000.
- Assert rst_ni in DRAIN after 2 of 3 sums -> outputs 0 immediately (asynchronous); after release, a fresh len=1 job returns only its own sum.
